// File: rtl/count4_up_sync.sv
// count4_up_sync: synchronous up counter with enable, parallel load,
// programmable modulus and a combinational terminal-count carry for cascading.
module count4_up_sync #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  // One extra bit so MODULUS == 2^WIDTH is representable in compares.
  localparam int unsigned     CW      = WIDTH + 1;
  localparam logic [CW-1:0]   MOD_EXT = CW'(MODULUS);
  localparam logic [WIDTH-1:0] TERM   = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] toggle;
  logic             at_term;
  logic             out_of_range;
  logic             d_in_range;

  // AND-chain toggle enables: bit i flips when en and all lower bits are 1.
  always_comb begin
    toggle[0] = en;
    for (int i = 1; i < int'(WIDTH); i++) begin
      toggle[i] = toggle[i-1] & q[i-1];
    end
  end

  // Range qualifiers for the wrap point, upset recovery and load clamping.
  always_comb begin
    at_term      = (q == TERM);
    out_of_range = ({1'b0, q} >= MOD_EXT);
    d_in_range   = ({1'b0, d} < MOD_EXT);
  end

  // Carry-out is same-cycle so a cascaded stage advances on the wrapping edge.
  assign tc = at_term & en;

  // Count state and wrap pulse; priority reset > load > en > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= d_in_range ? d : '0;
      wrap <= 1'b0;
    end else if (en) begin
      q    <= (at_term | out_of_range) ? '0 : (q ^ toggle);
      wrap <= at_term;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
